life_grid: RTL and testbench

- Parametrised ROWS x COLS Game-of-Life array for the LED-matrix life display; successor to the single per-cell block.
- Holds the whole grid, evaluates all cells in parallel, and advances one generation per prescaled tick.
- Adds the following, none of which the single-cell block has:
  - runtime birth/survive rule masks
  - toroidal or dead-edge boundary mode
  - single-step while paused
  - generation counter
  - population count
  - stable-pattern flag

---
 rtl/life_grid_if.sv | 34 +++
 rtl/life_grid.sv | 109 ++++++++++
 tb/tb_life_grid.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/life_grid_if.sv
// life_grid_if: control and observation bundle for the life_grid array.
// Latency: none (wires only). Backpressure: none; inputs are level-sampled each cycle.
// Ports: master drives pause/step/load/masks and observes grid/gen/population/tick/stable;
//        slave is the grid side.
interface life_grid_if #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
);
  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(N + 1);

  logic             pause;
  logic             step;
  logic             load_en;
  logic [N-1:0]     load_dat;
  logic [8:0]       birth_mask;
  logic [8:0]       survive_mask;
  logic [N-1:0]     grid_dat;
  logic [GEN_W-1:0] gen_count;
  logic [PW-1:0]    population;
  logic             tick;
  logic             stable;

  modport master (
    output pause, step, load_en, load_dat, birth_mask, survive_mask,
    input  grid_dat, gen_count, population, tick, stable
  );

  modport slave (
    input  pause, step, load_en, load_dat, birth_mask, survive_mask,
    output grid_dat, gen_count, population, tick, stable
  );
endinterface

// File: rtl/life_grid.sv
// life_grid: ROWS x COLS Game-of-Life array, all cells evaluated in parallel, one generation per tick.
// Latency: grid updates on the clock edge after an advance/load cycle; population/stable follow combinationally.
// Backpressure: none; Pause holds evolution, Step/load are only honoured while paused.
// Ports: clk_i, rst_i (synchronous, active-high); bus (life_grid_if.slave) carries
//        pause/step/load_en/load_dat/birth_mask/survive_mask in, grid_dat/gen_count/
//        population/tick/stable out. Grid bit r*COLS+c is cell (r,c).
module life_grid #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 256,
  parameter int WRAP     = 1,
  parameter int GEN_W    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  life_grid_if.slave  bus
);

  localparam int N   = ROWS * COLS;
  localparam int PW  = $clog2(N + 1);
  localparam int PCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PCW-1:0] PRE_TERM = PCW'(TICK_DIV - 1);

  logic [N-1:0]     grid_q, grid_d;
  logic [PCW-1:0]   pre_q, pre_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             tick_q;
  logic             pre_term;
  logic             do_load;
  logic             do_adv;
  wire  [N-1:0]     next_grid;

  // Per-cell neighbour count and rule lookup. Neighbour positions are resolved
  // at elaboration: with WRAP the index folds around the torus, otherwise an
  // out-of-grid neighbour is tied to 0.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      wire [7:0] nb;
      wire [3:0] cnt;

      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_use
          localparam int RR     = r + (k / 3) - 1;
          localparam int CC     = c + (k % 3) - 1;
          localparam int INSIDE = (RR >= 0 && RR < ROWS && CC >= 0 && CC < COLS) ? 1 : 0;
          localparam int RW     = (RR + ROWS) % ROWS;
          localparam int CWP    = (CC + COLS) % COLS;
          localparam int NK     = (k < 4) ? k : k - 1;
          if (INSIDE != 0 || WRAP != 0) begin : g_live
            assign nb[NK] = grid_q[RW*COLS + CWP];
          end else begin : g_dead
            assign nb[NK] = 1'b0;
          end
        end
      end

      assign cnt = {3'b000, nb[0]} + {3'b000, nb[1]} + {3'b000, nb[2]} + {3'b000, nb[3]}
                 + {3'b000, nb[4]} + {3'b000, nb[5]} + {3'b000, nb[6]} + {3'b000, nb[7]};

      assign next_grid[r*COLS + c] = grid_q[r*COLS + c] ? bus.survive_mask[cnt]
                                                       : bus.birth_mask[cnt];
    end
  end

  // Population as a ripple of partial sums over the grid bits.
  wire [PW-1:0] psum [0:N];
  assign psum[0] = '0;
  for (genvar i = 0; i < N; i++) begin : g_pop
    assign psum[i+1] = psum[i] + {{(PW-1){1'b0}}, grid_q[i]};
  end

  always_comb begin
    pre_term = (pre_q == PRE_TERM);
    do_load  = bus.pause & bus.load_en;
    // Load outranks Step; a run advance only happens while not paused.
    do_adv   = ~do_load & (bus.pause ? bus.step : pre_term);
    pre_d    = (bus.pause || pre_term) ? '0 : pre_q + PCW'(1);
    grid_d   = grid_q;
    gen_d    = gen_q;
    if (do_load) begin
      grid_d = bus.load_dat;
      gen_d  = '0;
    end else if (do_adv) begin
      grid_d = next_grid;
      gen_d  = gen_q + GEN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grid_q <= '0;
      pre_q  <= '0;
      gen_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      grid_q <= grid_d;
      pre_q  <= pre_d;
      gen_q  <= gen_d;
      tick_q <= do_adv;
    end
  end

  assign bus.grid_dat   = grid_q;
  assign bus.gen_count  = gen_q;
  assign bus.population = psum[N];
  assign bus.tick       = tick_q;
  assign bus.stable     = (next_grid == grid_q);

endmodule

// File: tb/tb_life_grid.sv
// tb_life_grid: directed checks of life_grid on three 5x5 instances
// (dead-edge TICK_DIV=4, toroidal TICK_DIV=1, dead-edge TICK_DIV=1).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_life_grid;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [24:0] ov;

  // Hand-built 5x5 patterns, bit r*5+c = cell (r,c).
  localparam logic [24:0] BL_H     = 25'h0003800; // (2,1),(2,2),(2,3)
  localparam logic [24:0] BL_V     = 25'h0021080; // (1,2),(2,2),(3,2)
  localparam logic [24:0] BLOCK    = 25'h00018C0; // (1,1),(1,2),(2,1),(2,2)
  localparam logic [24:0] GLIDER   = 25'h0001C82; // (0,1),(1,2),(2,0),(2,1),(2,2)
  localparam logic [24:0] GLIDER4  = 25'h0072080; // glider moved by (+1,+1)
  localparam logic [24:0] CORNER   = 25'h18C0000; // block (3,3),(3,4),(4,3),(4,4)
  localparam logic [24:0] HL_PAT   = 25'h00701C0; // rows 1 and 3, cols 1..3
  localparam logic [24:0] HL_CONW  = 25'h0420084; // (0,2),(1,2),(3,2),(4,2)
  localparam logic [24:0] HL_HIGH  = 25'h0421084; // same plus centre (2,2) born

  life_grid_if #(.ROWS(5), .COLS(5), .GEN_W(16)) bus_a ();
  life_grid_if #(.ROWS(5), .COLS(5), .GEN_W(16)) bus_b ();
  life_grid_if #(.ROWS(5), .COLS(5), .GEN_W(16)) bus_c ();

  life_grid #(.ROWS(5), .COLS(5), .TICK_DIV(4), .WRAP(0), .GEN_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a));
  life_grid #(.ROWS(5), .COLS(5), .TICK_DIV(1), .WRAP(1), .GEN_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b));
  life_grid #(.ROWS(5), .COLS(5), .TICK_DIV(1), .WRAP(0), .GEN_W(16)) dut_c (
    .clk_i(clk), .rst_i(rst), .bus(bus_c));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_a(input logic [24:0] pat);
    bus_a.load_en  = 1'b1;
    bus_a.load_dat = pat;
    cyc(1);
    bus_a.load_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.pause = 1'b1; bus_a.step = 1'b0; bus_a.load_en = 1'b0; bus_a.load_dat = '0;
    bus_b.pause = 1'b1; bus_b.step = 1'b0; bus_b.load_en = 1'b0; bus_b.load_dat = '0;
    bus_c.pause = 1'b1; bus_c.step = 1'b0; bus_c.load_en = 1'b0; bus_c.load_dat = '0;
    bus_a.birth_mask = 9'h008; bus_a.survive_mask = 9'h00C;
    bus_b.birth_mask = 9'h008; bus_b.survive_mask = 9'h00C;
    bus_c.birth_mask = 9'h008; bus_c.survive_mask = 9'h00C;
    cyc(2);

    // Reset state
    chk("rst_out",    64'(bus_a.grid_dat),   64'h0);
    chk("rst_gen",    64'(bus_a.gen_count),  64'h0);
    chk("rst_pop",    64'(bus_a.population), 64'h0);
    chk("rst_tick",   64'(bus_a.tick),       64'h0);
    chk("rst_stable", 64'(bus_a.stable),     64'h1);
    rst = 1'b0;

    // Blinker, dead edges, TICK_DIV=4
    load_a(BL_H);
    chk("bl_load_out",    64'(bus_a.grid_dat),   64'(BL_H));
    chk("bl_load_gen",    64'(bus_a.gen_count),  64'h0);
    chk("bl_load_pop",    64'(bus_a.population), 64'h3);
    chk("bl_load_stable", 64'(bus_a.stable),     64'h0);
    bus_a.pause = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk($sformatf("bl_out_c%0d", k),  64'(bus_a.grid_dat),
          (k >= 4 && k < 8) ? 64'(BL_V) : 64'(BL_H));
      chk($sformatf("bl_tick_c%0d", k), 64'(bus_a.tick), (k == 4 || k == 8) ? 64'h1 : 64'h0);
      chk($sformatf("bl_gen_c%0d", k),  64'(bus_a.gen_count), 64'(k / 4));
      chk($sformatf("bl_pop_c%0d", k),  64'(bus_a.population), 64'h3);
    end

    // Pause rising on the prescaler terminal cycle: no advance, prescaler restarts
    cyc(3);
    chk("pt_pre_out", 64'(bus_a.grid_dat), 64'(BL_H));
    bus_a.pause = 1'b1;
    cyc(1);
    chk("pt_hold_out",  64'(bus_a.grid_dat),  64'(BL_H));
    chk("pt_hold_gen",  64'(bus_a.gen_count), 64'h2);
    chk("pt_hold_tick", 64'(bus_a.tick),      64'h0);
    bus_a.pause = 1'b0;
    cyc(3);
    chk("pt_rel3_out", 64'(bus_a.grid_dat), 64'(BL_H));
    cyc(1);
    chk("pt_rel4_out",  64'(bus_a.grid_dat),  64'(BL_V));
    chk("pt_rel4_gen",  64'(bus_a.gen_count), 64'h3);
    chk("pt_rel4_tick", 64'(bus_a.tick),      64'h1);
    bus_a.pause = 1'b1;
    cyc(1);

    // Single Step while paused
    load_a(BL_H);
    bus_a.step = 1'b1;
    cyc(1);
    bus_a.step = 1'b0;
    chk("st1_out",  64'(bus_a.grid_dat),  64'(BL_V));
    chk("st1_gen",  64'(bus_a.gen_count), 64'h1);
    chk("st1_tick", 64'(bus_a.tick),      64'h1);
    cyc(3);
    chk("st1_idle_out",  64'(bus_a.grid_dat),  64'(BL_V));
    chk("st1_idle_gen",  64'(bus_a.gen_count), 64'h1);
    chk("st1_idle_tick", 64'(bus_a.tick),      64'h0);

    // Step held for three cycles
    load_a(BL_H);
    bus_a.step = 1'b1;
    cyc(3);
    bus_a.step = 1'b0;
    chk("st3_out", 64'(bus_a.grid_dat),  64'(BL_V));
    chk("st3_gen", 64'(bus_a.gen_count), 64'h3);

    // Step and load together: load wins
    bus_a.step = 1'b1; bus_a.load_en = 1'b1; bus_a.load_dat = BL_H;
    cyc(1);
    bus_a.step = 1'b0; bus_a.load_en = 1'b0;
    chk("stld_out", 64'(bus_a.grid_dat),  64'(BL_H));
    chk("stld_gen", 64'(bus_a.gen_count), 64'h0);
    cyc(1);
    chk("stld_tick", 64'(bus_a.tick), 64'h0);

    // Block still life over 10 stepped generations
    load_a(BLOCK);
    chk("blk_stable", 64'(bus_a.stable), 64'h1);
    bus_a.step = 1'b1;
    cyc(10);
    bus_a.step = 1'b0;
    chk("blk_out", 64'(bus_a.grid_dat),   64'(BLOCK));
    chk("blk_gen", 64'(bus_a.gen_count),  64'd10);
    chk("blk_pop", 64'(bus_a.population), 64'h4);

    // HighLife B36/S23 vs Conway on a centre cell with six neighbours
    load_a(HL_PAT);
    bus_a.birth_mask = 9'h048;
    bus_a.step = 1'b1;
    cyc(1);
    bus_a.step = 1'b0;
    chk("hl_b36_out", 64'(bus_a.grid_dat), 64'(HL_HIGH));
    ov = bus_a.grid_dat;
    chk("hl_b36_centre", 64'(ov[12]), 64'h1);
    load_a(HL_PAT);
    bus_a.birth_mask = 9'h008;
    bus_a.step = 1'b1;
    cyc(1);
    bus_a.step = 1'b0;
    chk("hl_b3_out", 64'(bus_a.grid_dat), 64'(HL_CONW));
    ov = bus_a.grid_dat;
    chk("hl_b3_centre", 64'(ov[12]), 64'h0);

    // Reset while running, prescaler at 2
    load_a(GLIDER);
    bus_a.pause = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("mrst_out",  64'(bus_a.grid_dat),   64'h0);
    chk("mrst_gen",  64'(bus_a.gen_count),  64'h0);
    chk("mrst_pop",  64'(bus_a.population), 64'h0);
    chk("mrst_tick", 64'(bus_a.tick),       64'h0);
    rst = 1'b0;
    cyc(8);
    chk("mrst_run_out",    64'(bus_a.grid_dat),   64'h0);
    chk("mrst_run_pop",    64'(bus_a.population), 64'h0);
    chk("mrst_run_stable", 64'(bus_a.stable),     64'h1);
    bus_a.pause = 1'b1;

    // Glider: torus (b) returns home after 20; dead edges (c) settles to a corner block
    bus_b.load_en = 1'b1; bus_b.load_dat = GLIDER;
    bus_c.load_en = 1'b1; bus_c.load_dat = GLIDER;
    cyc(1);
    bus_b.load_en = 1'b0; bus_c.load_en = 1'b0;
    bus_b.pause = 1'b0;   bus_c.pause = 1'b0;
    for (int g = 1; g <= 20; g++) begin
      cyc(1);
      chk($sformatf("gl_wrap_pop_g%0d", g), 64'(bus_b.population), 64'h5);
      if (g == 4) chk("gl_wrap_g4_out", 64'(bus_b.grid_dat), 64'(GLIDER4));
    end
    bus_b.pause = 1'b1; bus_c.pause = 1'b1;
    chk("gl_wrap_out", 64'(bus_b.grid_dat),  64'(GLIDER));
    chk("gl_wrap_gen", 64'(bus_b.gen_count), 64'd20);
    chk("gl_edge_out", 64'(bus_c.grid_dat),  64'(CORNER));
    ov = bus_c.grid_dat;
    chk("gl_edge_row0",   64'(ov[4:0]),          64'h0);
    chk("gl_edge_pop",    64'(bus_c.population), 64'h4);
    chk("gl_edge_stable", 64'(bus_c.stable),     64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
